// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Resolves, highest priority first: data-memory wait, taken redirect from X,
// fetch-refill bubbles after a redirect, and load-use hazards between X and D.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   inst_D_i, inst_X_i            instructions currently in D and X
//   memrd_X_i, regwen_X_i         X is a load / X writes rd
//   br_taken_X_i                  taken branch/jump resolved in X
//   dmem_busy_i                   LSU cannot finish the M-stage access
//   pc_en_o, fd_en_o, dx_en_o, xm_en_o      pipeline register enables
//   fd_flush_o, dx_flush_o, mw_flush_o      bubble injects
//   state_o                       0 RUN, 1 REDIRECT, 2 MEM_WAIT
//   stall_cnt_o, flush_cnt_o      saturating performance counters
module pipeline_hazard_ctrl #(
    parameter int unsigned REDIRECT_CYCLES = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      inst_D_i,
    input  logic [31:0]      inst_X_i,
    input  logic             memrd_X_i,
    input  logic             regwen_X_i,
    input  logic             br_taken_X_i,
    input  logic             dmem_busy_i,
    output logic             pc_en_o,
    output logic             fd_en_o,
    output logic             dx_en_o,
    output logic             xm_en_o,
    output logic             fd_flush_o,
    output logic             dx_flush_o,
    output logic             mw_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned RCNT_W = 3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    state_e            saved_q, saved_d;
    state_e            eff_state;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              redirect_acc;

    // Load-use detection: X load targets a register D actually reads.
    logic [6:0] op_d;
    logic [4:0] rs1_d, rs2_d, rd_x;
    logic       uses_rs1, uses_rs2, luh;
    logic       unused_inst;

    assign op_d     = inst_D_i[6:0];
    assign rs1_d    = inst_D_i[19:15];
    assign rs2_d    = inst_D_i[24:20];
    assign rd_x     = inst_X_i[11:7];
    assign uses_rs1 = !((op_d == OP_LUI) || (op_d == OP_AUIPC) || (op_d == OP_JAL));
    assign uses_rs2 = (op_d == OP_RTYPE) || (op_d == OP_STORE) || (op_d == OP_BRANCH);
    assign luh      = memrd_X_i && regwen_X_i && (rd_x != 5'd0) &&
                      (((rd_x == rs1_d) && uses_rs1) || ((rd_x == rs2_d) && uses_rs2));
    assign unused_inst = ^{inst_D_i[31:25], inst_D_i[14:7], inst_X_i[31:12], inst_X_i[6:0]};

    // Next-state and combinational control outputs.
    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        rcnt_d       = rcnt_q;
        redirect_acc = 1'b0;
        pc_en_o      = 1'b1;
        fd_en_o      = 1'b1;
        dx_en_o      = 1'b1;
        xm_en_o      = 1'b1;
        fd_flush_o   = 1'b0;
        dx_flush_o   = 1'b0;
        mw_flush_o   = 1'b0;
        // While waiting on memory, the interrupted state governs the release cycle.
        eff_state    = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

        if (dmem_busy_i) begin
            pc_en_o    = 1'b0;
            fd_en_o    = 1'b0;
            dx_en_o    = 1'b0;
            xm_en_o    = 1'b0;
            mw_flush_o = 1'b1;
            state_d    = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                saved_d = state_q;
            end
        end else if (br_taken_X_i) begin
            fd_flush_o   = 1'b1;
            dx_flush_o   = 1'b1;
            redirect_acc = 1'b1;
            if (REDIRECT_CYCLES > 1) begin
                rcnt_d  = RCNT_W'(REDIRECT_CYCLES - 1);
                state_d = ST_REDIRECT;
            end else begin
                rcnt_d  = '0;
                state_d = ST_RUN;
            end
        end else if (eff_state == ST_REDIRECT) begin
            fd_flush_o = 1'b1;
            rcnt_d     = rcnt_q - RCNT_W'(1);
            state_d    = (rcnt_q == RCNT_W'(1)) ? ST_RUN : ST_REDIRECT;
        end else begin
            state_d = ST_RUN;
            // Hold PC and F/D one cycle; the load moves on to M behind a bubble.
            if (luh) begin
                pc_en_o    = 1'b0;
                fd_en_o    = 1'b0;
                dx_flush_o = 1'b1;
            end
        end

        if (!rst_ni) begin
            pc_en_o    = 1'b0;
            fd_en_o    = 1'b0;
            dx_en_o    = 1'b0;
            xm_en_o    = 1'b0;
            fd_flush_o = 1'b1;
            dx_flush_o = 1'b1;
            mw_flush_o = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_acc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
